halt_monitor: RTL and testbench
===============================

Name: halt_monitor

Overview:
- Synthesizable run-status monitor directly downstream of dut_soc; consumes its halt and firstWord outputs.
- Counts clocks from reset and captures a one-time snapshot of firstWord and the cycle count on the first halt.
- Optionally flags protocol errors, then asserts done a fixed number of cycles after halt.
- Feeds board-level status LEDs/UART and the sim harness, replacing ad-hoc bench logic.

Parameters:
- CNT_W, 32: width of cycle counter and captured count.
- TIMEOUT, 10000: error if halt not seen once clkCnt exceeds this value.
- SETTLE, 5: cycles from halt capture to done.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst  input  1  asynchronous, active-high reset.
- halt  input  1  halt status from dut_soc.
- firstWord  input  16  status word from dut_soc.
- clkCnt  output  CNT_W  clock edges counted since reset release.
- wordAtHalt  output  16  firstWord sampled at first halt.
- clkAtHalt  output  CNT_W  clkCnt value at first halt.
- done  output  1  sticky; halt observed and settled.
- errValid  output  1  sticky; an error was detected.
- errCode  output  2  0 none, 1 timeout, 2 halt deasserted, 3 word changed.

Behaviour:
- Reset (async, rst=1): state=RUN; every output is 0 immediately, independent of clk.
- States: RUN, HALTED, DONE, ERROR. DONE and ERROR are terminal until reset.
- Counter: in RUN and HALTED, clkCnt <= clkCnt+1 each posedge, saturating at all-ones. In DONE and ERROR, clkCnt freezes.
- Let n be the incremented count for the current edge. All compares below use n.
- RUN, halt=1: go to HALTED; wordAtHalt <= firstWord; clkAtHalt <= n.
- RUN, halt=0 and n > TIMEOUT: go to ERROR with errCode=1.
- Halt and timeout on the same edge: the capture wins and no error is raised.
- HALTED: checks begin on the edge after capture.
  - halt=0: go to ERROR, errCode=2.
  - Otherwise, if firstWord != wordAtHalt: go to ERROR, errCode=3.
  - Both at once: errCode=2.
- HALTED, no error and n - clkAtHalt == SETTLE: go to DONE; done <= 1.
- Error and done on the same edge: error wins; done stays 0.
- done is first high on the edge where clkCnt becomes clkAtHalt+SETTLE.
- errValid = (state==ERROR); done = (state==DONE). Both are registered and mutually exclusive.
- Snapshot registers are never rewritten after capture until reset.
- Reset asserted mid-operation: abandons any state; counting restarts from 0 on the first posedge after rst falls.
- Subtraction n - clkAtHalt is CNT_W-bit unsigned. It cannot wrap because saturation occurs only beyond TIMEOUT+SETTLE for legal parameters.
- Parameter rule: require TIMEOUT+SETTLE < 2^CNT_W - 1.

Optional Feature:
- Macro: HALT_MON_CHECK_EN.
- Defined: the timeout and HALTED-state checks apply as described; the ERROR state is reachable.
- Undefined:
  - No checks; ERROR is unreachable; errValid and errCode are tied 0.
  - RUN waits indefinitely for halt.
  - HALTED goes to DONE purely on the SETTLE count.
  - Capture still occurs.

Test Plan:
1. Halt rises before edge 100, firstWord=16'h1234 held -> wordAtHalt=16'h1234, clkAtHalt=100; done rises when clkCnt=105; clkCnt holds 105 afterwards.
2. Halt never asserted, macro defined -> errValid=1, errCode=1 when clkCnt=10001; done stays 0. Macro undefined -> no error through clkCnt=20000.
3. Halt captured at 50, halt drops before edge 52 -> errCode=2 at clkCnt=52; done never rises.
4. Halt captured at 50, firstWord changes 16'h00AA->16'h00AB before edge 53 -> errCode=3 at clkCnt=53; wordAtHalt stays 16'h00AA.
5. Halt first seen exactly at edge 10001 -> clkAtHalt=10001 with no timeout error; done at clkCnt=10006.
6. rst pulsed mid-HALTED (clkCnt=102), asynchronous to clk -> all outputs 0 before the next edge; after release, a halt at edge 20 gives clkAtHalt=20 and done at 25.

Source files
------------

// File: rtl/halt_monitor.sv
// rtl/halt_monitor.sv - run-status monitor: cycle count, first-halt snapshot, settle-to-done
// Optional macro HALT_MON_CHECK_EN enables the timeout and post-halt stability checks (ERROR state).
module halt_monitor #(
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 10000,
  parameter int SETTLE  = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             halt,
  input  logic [15:0]      firstWord,
  output logic [CNT_W-1:0] clkCnt,
  output logic [15:0]      wordAtHalt,
  output logic [CNT_W-1:0] clkAtHalt,
  output logic             done,
  output logic             errValid,
  output logic [1:0]       errCode
);

  typedef enum logic [1:0] {RUN, HALTED, DONE, ERROR} state_t;

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] SETTLE_C = CNT_W'(SETTLE);

  // The settle subtraction relies on the counter never saturating before done can fire.
  if (SETTLE < 1 || (longint'(TIMEOUT) + longint'(SETTLE)) >= ((longint'(1) <<< CNT_W) - 1)) begin : gBadParams
    $error("halt_monitor: illegal CNT_W/TIMEOUT/SETTLE combination");
  end

  state_t           state;
  logic [CNT_W-1:0] nextCnt;
  logic [CNT_W-1:0] sinceHalt;

  assign nextCnt   = (&clkCnt) ? clkCnt : clkCnt + CNT_ONE;
  assign sinceHalt = nextCnt - clkAtHalt;

`ifdef HALT_MON_CHECK_EN
  localparam logic [CNT_W-1:0] TIMEOUT_C   = CNT_W'(TIMEOUT);
  localparam logic [1:0]       ERR_TIMEOUT = 2'd1;
  localparam logic [1:0]       ERR_DROP    = 2'd2;
  localparam logic [1:0]       ERR_WORD    = 2'd3;
`else
  assign errValid = 1'b0;
  assign errCode  = 2'd0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= RUN;
      clkCnt     <= '0;
      wordAtHalt <= '0;
      clkAtHalt  <= '0;
      done       <= 1'b0;
`ifdef HALT_MON_CHECK_EN
      errValid   <= 1'b0;
      errCode    <= 2'd0;
`endif
    end else begin
      case (state)
        RUN: begin
          clkCnt <= nextCnt;
          // Capture takes priority over a timeout landing on the same edge.
          if (halt) begin
            state      <= HALTED;
            wordAtHalt <= firstWord;
            clkAtHalt  <= nextCnt;
          end
`ifdef HALT_MON_CHECK_EN
          else if (nextCnt > TIMEOUT_C) begin
            state    <= ERROR;
            errValid <= 1'b1;
            errCode  <= ERR_TIMEOUT;
          end
`endif
        end
        HALTED: begin
          clkCnt <= nextCnt;
`ifdef HALT_MON_CHECK_EN
          if (!halt) begin
            state    <= ERROR;
            errValid <= 1'b1;
            errCode  <= ERR_DROP;
          end else if (firstWord != wordAtHalt) begin
            state    <= ERROR;
            errValid <= 1'b1;
            errCode  <= ERR_WORD;
          end else
`endif
          if (sinceHalt == SETTLE_C) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        default: begin
          // DONE and ERROR hold everything, including the counter, until reset.
        end
      endcase
    end
  end

endmodule

// File: tb/tb_halt_monitor.sv
// tb/tb_halt_monitor.sv - randomized and directed bench for halt_monitor against a trace-based model
`timescale 1ns/1ps
module tb_halt_monitor;

  localparam int CNT_W   = 32;
  localparam int TIMEOUT = 10000;
  localparam int SETTLE  = 5;
`ifdef HALT_MON_CHECK_EN
  localparam bit CHECKS = 1'b1;
`else
  localparam bit CHECKS = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             halt = 1'b0;
  logic [15:0]      firstWord = 16'h0;
  logic [CNT_W-1:0] clkCnt;
  logic [15:0]      wordAtHalt;
  logic [CNT_W-1:0] clkAtHalt;
  logic             done;
  logic             errValid;
  logic [1:0]       errCode;

  int nCompared = 0;
  int nMismatch = 0;

  // Input trace since the last reset, indexed by edge number (entry 0 unused).
  int haltQ[$];
  int wordQ[$];
  int edgeNo    = 0;
  int firstHalt = 0;

  int expCnt, expAt, expWord, expDone, expErr, expCode;

  always #5 clk = ~clk;

  halt_monitor #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT), .SETTLE(SETTLE)) dut (
    .clk(clk), .rst(rst), .halt(halt), .firstWord(firstWord),
    .clkCnt(clkCnt), .wordAtHalt(wordAtHalt), .clkAtHalt(clkAtHalt),
    .done(done), .errValid(errValid), .errCode(errCode)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatch++;
      $display("FAIL %s: got %0d expected %0d (edge %0d, t=%0t)", name, act, exp, edgeNo, $time);
    end
  endtask

  // Outcome after edge e derived from the whole trace: the first halt, the window that follows it,
  // and the edge at which the run becomes terminal (timeout, violation or settle).
  task automatic evalModel(input int e);
    int term, code, c, lim, last;
    term = 0; code = 0; c = firstHalt; lim = TIMEOUT + 1;
    if (CHECKS && (c == 0 || c > lim)) begin
      c = 0;
      if (e >= lim) begin term = lim; code = 1; end
    end else if (c != 0) begin
      term = c + SETTLE;
      if (CHECKS) begin
        last = (e < c + SETTLE) ? e : c + SETTLE;
        for (int k = c + 1; k <= last; k++) begin
          if (haltQ[k] == 0) begin term = k; code = 2; break; end
          if (wordQ[k] != wordQ[c]) begin term = k; code = 3; break; end
        end
      end
    end
    expAt   = c;
    expWord = (c != 0) ? wordQ[c] : 0;
    if (term != 0 && e >= term) begin
      expCnt = term; expDone = (code == 0); expErr = (code != 0); expCode = code;
    end else begin
      expCnt = e; expDone = 0; expErr = 0; expCode = 0;
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      haltQ.delete(); wordQ.delete();
      haltQ.push_back(0); wordQ.push_back(0);
      edgeNo = 0; firstHalt = 0;
      check("rst_clkCnt", clkCnt, 0);
      check("rst_done", done, 0);
      check("rst_errValid", errValid, 0);
      check("rst_errCode", errCode, 0);
      check("rst_clkAtHalt", clkAtHalt, 0);
      check("rst_wordAtHalt", wordAtHalt, 0);
    end else begin
      edgeNo++;
      haltQ.push_back(int'(halt));
      wordQ.push_back(int'(firstWord));
      if (firstHalt == 0 && halt) firstHalt = edgeNo;
      evalModel(edgeNo);
      check("clkCnt", clkCnt, expCnt);
      check("clkAtHalt", clkAtHalt, expAt);
      check("wordAtHalt", wordAtHalt, expWord);
      check("done", done, expDone);
      check("errValid", errValid, expErr);
      check("errCode", errCode, expCode);
    end
  end

  task automatic releaseReset();
    halt = 1'b0; firstWord = 16'h0; rst = 1'b1;
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
  endtask

  // Inputs applied here are sampled by the next posedge.
  task automatic drive(input logic h, input logic [15:0] w);
    halt = h; firstWord = w;
    @(negedge clk);
    #2;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c, mode, dropAt, chgAt, len;
    logic h;
    logic [15:0] base, w;

    // Halt at edge 100 with a stable word.
    releaseReset();
    for (int k = 1; k <= 110; k++) drive(k >= 100, 16'h1234);
    check("t1_word", wordAtHalt, 16'h1234);
    check("t1_clkAtHalt", clkAtHalt, 100);
    check("t1_clkCnt", clkCnt, 105);
    check("t1_done", done, 1);

    // Halt never asserted.
    releaseReset();
`ifdef HALT_MON_CHECK_EN
    for (int k = 1; k <= 10003; k++) drive(1'b0, 16'($urandom));
    check("t2_err", errValid, 1);
    check("t2_code", errCode, 1);
    check("t2_clkCnt", clkCnt, 10001);
    check("t2_done", done, 0);
`else
    for (int k = 1; k <= 20000; k++) drive(1'b0, 16'($urandom));
    check("t2_err", errValid, 0);
    check("t2_clkCnt", clkCnt, 20000);
    check("t2_done", done, 0);
`endif

    // Halt captured at 50, dropped at edge 52.
    releaseReset();
    for (int k = 1; k <= 60; k++) drive(k >= 50 && k < 52, 16'h0042);
`ifdef HALT_MON_CHECK_EN
    check("t3_code", errCode, 2);
    check("t3_clkCnt", clkCnt, 52);
    check("t3_done", done, 0);
`else
    check("t3_clkCnt", clkCnt, 55);
    check("t3_done", done, 1);
`endif

    // Halt captured at 50, word changes at edge 53.
    releaseReset();
    for (int k = 1; k <= 60; k++) drive(k >= 50, (k < 53) ? 16'h00AA : 16'h00AB);
    check("t4_word", wordAtHalt, 16'h00AA);
`ifdef HALT_MON_CHECK_EN
    check("t4_code", errCode, 3);
    check("t4_clkCnt", clkCnt, 53);
`else
    check("t4_clkCnt", clkCnt, 55);
    check("t4_done", done, 1);
`endif

    // Halt first seen on the timeout edge.
    releaseReset();
    for (int k = 1; k <= 10010; k++) drive(k >= 10001, 16'h7777);
    check("t5_clkAtHalt", clkAtHalt, 10001);
    check("t5_err", errValid, 0);
    check("t5_clkCnt", clkCnt, 10006);
    check("t5_done", done, 1);

    // Asynchronous reset in the middle of HALTED.
    releaseReset();
    for (int k = 1; k <= 102; k++) drive(k >= 100, 16'h5A5A);
    check("t6_pre_clkCnt", clkCnt, 102);
    #1 rst = 1'b1; halt = 1'b0;
    #1;
    check("t6_async_clkCnt", clkCnt, 0);
    check("t6_async_clkAtHalt", clkAtHalt, 0);
    check("t6_async_word", wordAtHalt, 0);
    check("t6_async_done", done, 0);
    @(negedge clk);
    #2 rst = 1'b0;
    for (int k = 1; k <= 30; k++) drive(k >= 20, 16'h0F0F);
    check("t6_clkAtHalt", clkAtHalt, 20);
    check("t6_clkCnt", clkCnt, 25);
    check("t6_done", done, 1);

    // Randomized capture, glitches and word changes; per-cycle model comparison covers these.
    for (int t = 0; t < 25; t++) begin
      releaseReset();
      c      = $urandom_range(1, 150);
      mode   = $urandom_range(0, 3);
      dropAt = c + $urandom_range(1, SETTLE + 1);
      chgAt  = c + $urandom_range(1, SETTLE + 1);
      base   = 16'($urandom);
      len    = c + SETTLE + 10;
      for (int k = 1; k <= len; k++) begin
        h = (k >= c) || ($urandom_range(0, 199) == 0);
        if (mode[0] && k == dropAt) h = 1'b0;
        w = (mode[1] && k >= chgAt) ? ~base : base;
        if (k > c + SETTLE + 1) begin
          h = 1'($urandom);
          w = 16'($urandom);
        end
        drive(h, w);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end

endmodule
